// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage. Decodes the ID/EX instruction word, computes
// ALU / link results, load-store addresses and branch outcomes, and registers
// them toward MEM. A taken branch/jump raises a one-cycle redirect pulse and
// squashes the single wrong-path instruction that follows it.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic [31:0] ex_opr1,
    input  logic [31:0] ex_opr2,
    input  logic [31:0] ex_opr3,
    input  logic [31:0] ex_opr4,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_inst,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_sdata,
    output logic [3:0]  mem_op,
    output logic        branch_interception,
    output logic [31:0] branch_target
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    opcode_e     opcode;
    logic [2:0]  funct3;
    logic        bit30;
    logic        kill;

    logic [31:0] res_n;
    logic        wreg_n;
    mem_op_e     op_n;
    logic        taken_n;
    logic [31:0] target_n;
    logic [31:0] ea;
    logic [31:0] jalr_sum;

    logic unused_inst_bits;

    assign opcode   = opcode_e'(ex_inst[6:0]);
    assign funct3   = ex_inst[14:12];
    assign bit30    = ex_inst[30];
    assign ea       = ex_opr1 + ex_opr3;
    assign jalr_sum = ex_opr1 + ex_opr3;
    assign unused_inst_bits = ^{ex_inst[31], ex_inst[29:15], ex_inst[11:7]};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic sub,
                                        input logic arith);
        logic [31:0] r;
        case (f3)
            3'b000:  r = sub ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = arith ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Decode the incoming instruction into next-cycle results and redirect.
    always_comb begin
        res_n    = '0;
        wreg_n   = 1'b0;
        op_n     = MEM_NONE;
        taken_n  = 1'b0;
        target_n = ex_opr4 + ex_opr3;
        case (opcode)
            OPC_OP: begin
                res_n  = alu(ex_opr1, ex_opr2, funct3, bit30, bit30);
                wreg_n = ex_wreg;
            end
            OPC_OPIMM: begin
                res_n  = alu(ex_opr1, ex_opr3, funct3, 1'b0, bit30);
                wreg_n = ex_wreg;
            end
            OPC_LUI: begin
                res_n  = ex_opr3;
                wreg_n = ex_wreg;
            end
            OPC_AUIPC: begin
                res_n  = ex_opr4 + ex_opr3;
                wreg_n = ex_wreg;
            end
            OPC_JAL: begin
                res_n   = ex_opr4 + 32'd4;
                wreg_n  = ex_wreg;
                taken_n = 1'b1;
            end
            OPC_JALR: begin
                res_n    = ex_opr4 + 32'd4;
                wreg_n   = ex_wreg;
                taken_n  = 1'b1;
                target_n = {jalr_sum[31:1], 1'b0};
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  taken_n = (ex_opr1 == ex_opr2);
                    3'b001:  taken_n = (ex_opr1 != ex_opr2);
                    3'b100:  taken_n = ($signed(ex_opr1) <  $signed(ex_opr2));
                    3'b101:  taken_n = ($signed(ex_opr1) >= $signed(ex_opr2));
                    3'b110:  taken_n = (ex_opr1 <  ex_opr2);
                    3'b111:  taken_n = (ex_opr1 >= ex_opr2);
                    default: taken_n = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  op_n = MEM_LB;
                    3'b001:  op_n = MEM_LH;
                    3'b010:  op_n = MEM_LW;
                    3'b100:  op_n = MEM_LBU;
                    3'b101:  op_n = MEM_LHU;
                    default: op_n = MEM_NONE;
                endcase
                wreg_n = ex_wreg && (op_n != MEM_NONE);
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  op_n = MEM_SB;
                    3'b001:  op_n = MEM_SH;
                    3'b010:  op_n = MEM_SW;
                    default: op_n = MEM_NONE;
                endcase
            end
            default: ;
        endcase
    end

    // Pipeline register: stall freezes everything except the redirect pulse,
    // which always drops after one cycle; a pending kill turns the slot into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd              <= '0;
            mem_wreg            <= 1'b0;
            mem_wdata           <= '0;
            mem_addr            <= '0;
            mem_sdata           <= '0;
            mem_op              <= '0;
            branch_interception <= 1'b0;
            branch_target       <= '0;
            kill                <= 1'b0;
        end else if (ex_stall) begin
            branch_interception <= 1'b0;
        end else if (kill) begin
            mem_wd              <= '0;
            mem_wreg            <= 1'b0;
            mem_wdata           <= '0;
            mem_addr            <= '0;
            mem_sdata           <= '0;
            mem_op              <= '0;
            branch_interception <= 1'b0;
            kill                <= 1'b0;
        end else begin
            mem_wd              <= ex_wd;
            mem_wreg            <= wreg_n;
            mem_wdata           <= res_n;
            mem_addr            <= ea;
            mem_sdata           <= ex_opr2;
            mem_op              <= op_n;
            branch_interception <= taken_n;
            kill                <= taken_n;
            if (taken_n)
                branch_target <= target_n;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed expectations for ex_stage.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_stall;
    logic [31:0] ex_opr1, ex_opr2, ex_opr3, ex_opr4;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_inst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_addr, mem_sdata;
    logic [3:0]  mem_op;
    logic        branch_interception;
    logic [31:0] branch_target;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                           BR = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;

    ex_stage dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall),
        .ex_opr1(ex_opr1), .ex_opr2(ex_opr2), .ex_opr3(ex_opr3), .ex_opr4(ex_opr4),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_inst(ex_inst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .mem_op(mem_op),
        .branch_interception(branch_interception), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic b30);
        return {1'b0, b30, 15'd0, f3, 5'd0, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] o3, input logic [31:0] o4,
                         input logic [4:0] wd, input logic wreg);
        ex_inst = inst; ex_opr1 = o1; ex_opr2 = o2; ex_opr3 = o3; ex_opr4 = o4;
        ex_wd = wd; ex_wreg = wreg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wd"},    {27'd0, mem_wd}, 32'd0);
        chk({tag, "_wreg"},  {31'd0, mem_wreg}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_sdata"}, mem_sdata, 32'd0);
        chk({tag, "_op"},    {28'd0, mem_op}, 32'd0);
        chk({tag, "_bi"},    {31'd0, branch_interception}, 32'd0);
        chk({tag, "_tgt"},   branch_target, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_stall = 1'b0;
        drive(mk(JAL, 3'd0, 1'b0), 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            ex_stall = 1'($urandom);
            drive(mk(JAL, 3'd0, 1'b0), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'b1);
            tick();
            chk_zero("reset");
        end
        rst = 1'b0; ex_stall = 1'b0;

        // ADDI x5, 0xFFFFFFFF + 1
        drive(mk(OPIMM, 3'b000, 1'b0), 32'hFFFF_FFFF, 32'h0, 32'd1, 32'h0, 5'd5, 1'b1);
        tick();
        chk("addi_wdata", mem_wdata, 32'h0);
        chk("addi_wd",    {27'd0, mem_wd}, 32'd5);
        chk("addi_wreg",  {31'd0, mem_wreg}, 32'd1);
        chk("addi_op",    {28'd0, mem_op}, 32'd0);
        chk("addi_bi",    {31'd0, branch_interception}, 32'd0);

        drive(mk(OP, 3'b000, 1'b1), 32'd3, 32'd5, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        chk("sub", mem_wdata, 32'hFFFF_FFFE);

        drive(mk(OP, 3'b101, 1'b1), 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        chk("sra", mem_wdata, 32'hF800_0000);

        drive(mk(OP, 3'b101, 1'b0), 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        chk("srl", mem_wdata, 32'h0800_0000);

        drive(mk(OP, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        chk("slt", mem_wdata, 32'd1);

        drive(mk(OP, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        chk("sltu", mem_wdata, 32'd0);

        drive(mk(OPIMM, 3'b101, 1'b1), 32'h8000_0000, 32'h0, 32'h0000_0404, 32'h0, 5'd8, 1'b1);
        tick();
        chk("srai", mem_wdata, 32'hF800_0000);

        drive(mk(OPIMM, 3'b000, 1'b1), 32'd10, 32'h0, 32'd3, 32'h0, 5'd8, 1'b1);
        tick();
        chk("addi_b30_no_sub", mem_wdata, 32'd13);

        drive(mk(LUI, 3'b000, 1'b0), 32'h0, 32'h0, 32'h1234_5000, 32'h0, 5'd9, 1'b1);
        tick();
        chk("lui", mem_wdata, 32'h1234_5000);

        drive(mk(AUIPC, 3'b000, 1'b0), 32'h0, 32'h0, 32'h0000_1000, 32'h100, 5'd9, 1'b1);
        tick();
        chk("auipc", mem_wdata, 32'h0000_1100);

        // BEQ taken, then squashed ADDI x1, then normal ADDI x2
        drive(mk(BR, 3'b000, 1'b0), 32'd7, 32'd7, 32'h20, 32'h100, 5'd3, 1'b1);
        tick();
        chk("beq_bi",   {31'd0, branch_interception}, 32'd1);
        chk("beq_tgt",  branch_target, 32'h120);
        chk("beq_wreg", {31'd0, mem_wreg}, 32'd0);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd1, 32'h0, 32'd1, 32'h104, 5'd1, 1'b1);
        tick();
        chk("beq_squash_bi",   {31'd0, branch_interception}, 32'd0);
        chk("beq_squash_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("beq_squash_op",   {28'd0, mem_op}, 32'd0);
        chk("beq_tgt_hold",    branch_target, 32'h120);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd2, 32'h0, 32'd3, 32'h108, 5'd2, 1'b1);
        tick();
        chk("after_beq_wdata", mem_wdata, 32'd5);
        chk("after_beq_wreg",  {31'd0, mem_wreg}, 32'd1);
        chk("after_beq_wd",    {27'd0, mem_wd}, 32'd2);

        // BNE not taken, BLTU not taken on -1 vs 1
        drive(mk(BR, 3'b001, 1'b0), 32'd7, 32'd7, 32'h20, 32'h100, 5'd0, 1'b0);
        tick();
        chk("bne_nt_bi",  {31'd0, branch_interception}, 32'd0);
        chk("bne_nt_tgt", branch_target, 32'h120);
        drive(mk(BR, 3'b110, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0, 1'b0);
        tick();
        chk("bltu_nt_bi", {31'd0, branch_interception}, 32'd0);

        // JALR, then back-to-back JAL squashed, then normal ADDI
        drive(mk(JALR, 3'b000, 1'b0), 32'h203, 32'h0, 32'h0, 32'h40, 5'd1, 1'b1);
        tick();
        chk("jalr_bi",    {31'd0, branch_interception}, 32'd1);
        chk("jalr_tgt",   branch_target, 32'h202);
        chk("jalr_wdata", mem_wdata, 32'h44);
        chk("jalr_wreg",  {31'd0, mem_wreg}, 32'd1);
        drive(mk(JAL, 3'b000, 1'b0), 32'h0, 32'h0, 32'h100, 32'h44, 5'd1, 1'b1);
        tick();
        chk("jal_b2b_bi",   {31'd0, branch_interception}, 32'd0);
        chk("jal_b2b_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("jal_b2b_tgt",  branch_target, 32'h202);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd20, 32'h0, 32'd1, 32'h48, 5'd4, 1'b1);
        tick();
        chk("after_b2b_wdata", mem_wdata, 32'd21);
        chk("after_b2b_wreg",  {31'd0, mem_wreg}, 32'd1);

        // Stores and loads
        drive(mk(STORE, 3'b010, 1'b0), 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 5'd0, 1'b1);
        tick();
        chk("sw_addr",  mem_addr, 32'h0000_0FFC);
        chk("sw_op",    {28'd0, mem_op}, 32'd8);
        chk("sw_sdata", mem_sdata, 32'hDEAD_BEEF);
        chk("sw_wreg",  {31'd0, mem_wreg}, 32'd0);
        drive(mk(LOAD, 3'b100, 1'b0), 32'h2000, 32'h0, 32'd3, 32'h0, 5'd10, 1'b1);
        tick();
        chk("lbu_op",   {28'd0, mem_op}, 32'd4);
        chk("lbu_addr", mem_addr, 32'h2003);
        chk("lbu_wreg", {31'd0, mem_wreg}, 32'd1);
        drive(mk(LOAD, 3'b010, 1'b0), 32'h2000, 32'h0, 32'd8, 32'h0, 5'd10, 1'b1);
        tick();
        chk("lw_op", {28'd0, mem_op}, 32'd3);
        drive(mk(STORE, 3'b000, 1'b0), 32'h3000, 32'h55, 32'd1, 32'h0, 5'd0, 1'b0);
        tick();
        chk("sb_op", {28'd0, mem_op}, 32'd6);

        // Unknown opcode and all-zero bubble are nops
        drive(32'h0000_007F, 32'd1, 32'd1, 32'd1, 32'd1, 5'd11, 1'b1);
        tick();
        chk("unknown_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("unknown_op",   {28'd0, mem_op}, 32'd0);
        chk("unknown_bi",   {31'd0, branch_interception}, 32'd0);
        drive(32'h0, 32'd1, 32'd1, 32'd1, 32'd1, 5'd11, 1'b1);
        tick();
        chk("bubble_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("bubble_bi",   {31'd0, branch_interception}, 32'd0);

        // Stall three cycles with a taken JAL waiting
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd10, 32'h0, 32'd1, 32'h0, 5'd3, 1'b1);
        tick();
        chk("pre_stall_wdata", mem_wdata, 32'd11);
        ex_stall = 1'b1;
        drive(mk(JAL, 3'b000, 1'b0), 32'h0, 32'h0, 32'h40, 32'h80, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wdata", mem_wdata, 32'd11);
            chk("stall_wd",    {27'd0, mem_wd}, 32'd3);
            chk("stall_wreg",  {31'd0, mem_wreg}, 32'd1);
            chk("stall_bi",    {31'd0, branch_interception}, 32'd0);
            chk("stall_tgt",   branch_target, 32'h202);
        end
        ex_stall = 1'b0;
        tick();
        chk("stall_jal_bi",    {31'd0, branch_interception}, 32'd1);
        chk("stall_jal_tgt",   branch_target, 32'hC0);
        chk("stall_jal_wdata", mem_wdata, 32'h84);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd1, 32'h0, 32'd1, 32'h84, 5'd4, 1'b1);
        tick();
        chk("stall_squash_bi",   {31'd0, branch_interception}, 32'd0);
        chk("stall_squash_wreg", {31'd0, mem_wreg}, 32'd0);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd4, 32'h0, 32'd4, 32'hC0, 5'd4, 1'b1);
        tick();
        chk("after_stall_wdata", mem_wdata, 32'd8);

        // Stall arriving during the pulse: pulse drops, kill is held
        drive(mk(BR, 3'b000, 1'b0), 32'd1, 32'd1, 32'd8, 32'h200, 5'd0, 1'b0);
        tick();
        chk("beq2_bi",  {31'd0, branch_interception}, 32'd1);
        chk("beq2_tgt", branch_target, 32'h208);
        ex_stall = 1'b1;
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd5, 32'h0, 32'd5, 32'h204, 5'd6, 1'b1);
        tick();
        chk("pulse_stall_bi",  {31'd0, branch_interception}, 32'd0);
        chk("pulse_stall_tgt", branch_target, 32'h208);
        ex_stall = 1'b0;
        tick();
        chk("pulse_stall_squash_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("pulse_stall_squash_bi",   {31'd0, branch_interception}, 32'd0);
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd6, 32'h0, 32'd6, 32'h208, 5'd6, 1'b1);
        tick();
        chk("after_pulse_stall_wdata", mem_wdata, 32'd12);
        chk("after_pulse_stall_wreg",  {31'd0, mem_wreg}, 32'd1);

        // Reset overrides stall and a pending kill
        drive(mk(JAL, 3'b000, 1'b0), 32'h0, 32'h0, 32'h10, 32'h300, 5'd1, 1'b1);
        tick();
        chk("jal3_bi", {31'd0, branch_interception}, 32'd1);
        rst = 1'b1; ex_stall = 1'b1;
        tick();
        chk_zero("rst_override");
        rst = 1'b0; ex_stall = 1'b0;
        drive(mk(OPIMM, 3'b000, 1'b0), 32'd7, 32'h0, 32'd8, 32'h0, 5'd12, 1'b1);
        tick();
        chk("post_rst_wdata", mem_wdata, 32'd15);
        chk("post_rst_wreg",  {31'd0, mem_wreg}, 32'd1);
        chk("post_rst_wd",    {27'd0, mem_wd}, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
